spram_be_clr: RTL and testbench

Parametrised single-port data RAM for the dcache, successor to the fixed 32x8 array. It adds configurable width and depth, per-byte write enables, a registered read port with a valid strobe, and a built-in clear engine. The clear engine zeroes every word after reset or on request, so tag and valid stores start from a known state. It sits under the dcache controller as the storage for data, tag and valid arrays.

---
 rtl/dcache_pkg.sv | 7 +
 rtl/spram_be_core.sv | 43 ++++
 rtl/spram_be_clr.sv | 104 ++++++++++
 tb/tb_spram_be_clr.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared constants for the dcache storage arrays: lane width and clear-FSM encoding.
package dcache_pkg;
  localparam int LANEBITS = 8;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;
endpackage

// File: rtl/spram_be_core.sv
// Single-port storage array: byte-enabled synchronous write, registered read-first output.
// Latency 1 cycle; no backpressure, every access presented is performed.
module spram_be_core
  import dcache_pkg::*;
#(
  parameter int DATABITS = 32,
  parameter int ADDRBITS = 5,
  parameter int MEMSIZE  = 2**ADDRBITS,
  parameter int BYTES    = DATABITS/LANEBITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDRBITS-1:0] addr,
  input  logic [DATABITS-1:0] wdata,
  input  logic [BYTES-1:0]    be,
  input  logic                we,
  input  logic                re,
  output logic [DATABITS-1:0] rdata
);

  logic [DATABITS-1:0] memblock [MEMSIZE];
  logic [DATABITS-1:0] rdata_q;

  // The array is deliberately unreset; the clear engine above gives it a known state.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BYTES; i++) begin
        if (be[i]) memblock[addr][i*LANEBITS +: LANEBITS] <= wdata[i*LANEBITS +: LANEBITS];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= memblock[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/spram_be_clr.sv
// Single-port byte-enabled RAM with a clear engine that zeroes every word after reset or on request.
// Read latency 1 cycle; ready is low for MEMSIZE cycles while clearing and accesses are dropped.
module spram_be_clr
  import dcache_pkg::*;
#(
  parameter int DATABITS = 32,
  parameter int ADDRBITS = 5,
  parameter int MEMSIZE  = 2**ADDRBITS,
  parameter int BYTES    = DATABITS/LANEBITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDRBITS-1:0] addr,
  input  logic [DATABITS-1:0] data_in,
  input  logic [BYTES-1:0]    be,
  input  logic                we,
  input  logic                re,
  input  logic                clear,
  output logic [DATABITS-1:0] data_out,
  output logic                rvalid,
  output logic                ready
);

  localparam logic [ADDRBITS-1:0] LAST_ADDR = ADDRBITS'(MEMSIZE-1);

  logic [0:0]          state_q, state_d;
  logic [ADDRBITS-1:0] clr_addr_q, clr_addr_d;
  logic                ready_q, ready_d;
  logic                rvalid_q, rvalid_d;

  logic [ADDRBITS-1:0] m_addr;
  logic [DATABITS-1:0] m_wdata;
  logic [BYTES-1:0]    m_be;
  logic                m_we;
  logic                m_re;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    ready_d    = ready_q;
    rvalid_d   = 1'b0;
    m_addr     = addr;
    m_wdata    = data_in;
    m_be       = be;
    m_we       = 1'b0;
    m_re       = 1'b0;
    if (state_q == ST_CLEAR) begin
      m_addr     = clr_addr_q;
      m_wdata    = '0;
      m_be       = '1;
      m_we       = 1'b1;
      clr_addr_d = clr_addr_q + 1'b1;
      if (clr_addr_q == LAST_ADDR) begin
        state_d    = ST_IDLE;
        ready_d    = 1'b1;
        clr_addr_d = '0;
      end
    end else begin
      m_we     = we;
      m_re     = re;
      rvalid_d = re;
      // The access sampled alongside clear still completes before the sweep starts.
      if (clear) begin
        state_d    = ST_CLEAR;
        clr_addr_d = '0;
        ready_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      ready_q    <= 1'b0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      ready_q    <= ready_d;
      rvalid_q   <= rvalid_d;
    end
  end

  spram_be_core #(
    .DATABITS (DATABITS),
    .ADDRBITS (ADDRBITS),
    .MEMSIZE  (MEMSIZE),
    .BYTES    (BYTES)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .addr  (m_addr),
    .wdata (m_wdata),
    .be    (m_be),
    .we    (m_we),
    .re    (m_re),
    .rdata (data_out)
  );

  assign ready  = ready_q;
  assign rvalid = rvalid_q;

endmodule

// File: tb/tb_spram_be_clr.sv
// Directed bench for spram_be_clr: default 32x32 instance against a scoreboarded model, plus a 64x8 instance.
module tb_spram_be_clr;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  addr;
  logic [31:0] data_in;
  logic [3:0]  be;
  logic        we, re, clear;
  logic [31:0] data_out;
  logic        rvalid, ready;

  logic        rst64;
  logic [2:0]  a64;
  logic [63:0] d64;
  logic [7:0]  be64;
  logic        we64, re64, clr64;
  logic [63:0] dout64;
  logic        rv64, rdy64;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_mem [32];
  bit          m_ready;
  int          m_cnt;
  logic [31:0] m_dout;
  logic [31:0] sbq [$];

  always #5 clk = ~clk;

  spram_be_clr dut (
    .clk (clk), .reset (reset), .addr (addr), .data_in (data_in), .be (be),
    .we (we), .re (re), .clear (clear), .data_out (data_out), .rvalid (rvalid), .ready (ready)
  );

  spram_be_clr #(.DATABITS(64), .ADDRBITS(3)) dut64 (
    .clk (clk), .reset (rst64), .addr (a64), .data_in (d64), .be (be64),
    .we (we64), .re (re64), .clear (clr64), .data_out (dout64), .rvalid (rv64), .ready (rdy64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Model advances on the edge using the inputs currently driven, then DUT is sampled 1ns later.
  task automatic tick();
    if (m_ready) begin
      if (re) sbq.push_back(m_mem[addr]);
      if (we) for (int i = 0; i < 4; i++) if (be[i]) m_mem[addr][8*i +: 8] = data_in[8*i +: 8];
      if (clear) begin
        m_ready = 1'b0;
        m_cnt   = 0;
      end
    end else begin
      m_mem[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == 32) m_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("ready", 64'(ready), 64'(m_ready));
    check("rvalid", 64'(rvalid), 64'(sbq.size() != 0));
    if (sbq.size() != 0) m_dout = sbq.pop_front();
    check("data_out", 64'(data_out), 64'(m_dout));
  endtask

  task automatic drive(input logic w, input logic r, input logic c,
                       input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
    we = w; re = r; clear = c; addr = a; data_in = d; be = b;
    tick();
  endtask

  task automatic model_reset();
    m_ready = 1'b0;
    m_cnt   = 0;
    m_dout  = '0;
    sbq.delete();
  endtask

  task automatic wait_ready(input string tag, input int exp_cycles);
    int cnt = 0;
    we = 0; re = 0; clear = 0;
    while (!ready && cnt < 100) begin
      tick();
      cnt++;
    end
    check(tag, 64'(cnt), 64'(exp_cycles));
  endtask

  initial begin
    int cnt;
    reset = 1'b1; we = 0; re = 0; clear = 0; addr = '0; data_in = '0; be = '0;
    rst64 = 1'b1; we64 = 0; re64 = 0; clr64 = 0; a64 = '0; d64 = '0; be64 = '0;
    for (int i = 0; i < 32; i++) m_mem[i] = 32'hxxxx_xxxx;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(ready), 64'(0));
    check("rst_rvalid", 64'(rvalid), 64'(0));
    check("rst_data_out", 64'(data_out), 64'(0));
    reset = 1'b0;

    wait_ready("clear_cycles", 32);
    for (int a = 0; a < 32; a++) drive(0, 1, 0, 5'(a), '0, '0);
    drive(0, 0, 0, '0, '0, '0);

    // Byte-lane merge.
    drive(1, 0, 0, 5'd3, 32'hDEADBEEF, 4'b1111);
    drive(1, 0, 0, 5'd3, 32'h000000AA, 4'b0001);
    drive(1, 0, 0, 5'd3, 32'h55555555, 4'b0000);
    drive(0, 1, 0, 5'd3, '0, '0);
    drive(0, 0, 0, '0, '0, '0);
    check("merge_addr3", 64'(m_dout), 64'h0000_0000_DEAD_BEAA);

    // Read-first on simultaneous read and write.
    drive(1, 1, 0, 5'd5, 32'h12345678, 4'b1111);
    drive(0, 1, 0, 5'd5, '0, '0);
    drive(0, 0, 0, '0, '0, '0);

    // Clear with a concurrent read; accesses during the sweep are dropped.
    drive(1, 0, 0, 5'd7, 32'hFFFFFFFF, 4'b1111);
    drive(0, 1, 1, 5'd7, '0, '0);
    for (int i = 0; i < 32; i++)
      drive(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 31)), $urandom, 4'($urandom));
    drive(0, 1, 0, 5'd7, '0, '0);
    drive(0, 1, 0, 5'd5, '0, '0);
    drive(0, 0, 0, '0, '0, '0);

    // Reset in the middle of a clear sweep.
    drive(1, 0, 0, 5'd3, 32'hCAFEF00D, 4'b1111);
    drive(0, 1, 1, 5'd3, '0, '0);
    for (int i = 0; i < 9; i++) drive(0, 0, 0, '0, '0, '0);
    reset = 1'b1;
    #1;
    check("midclr_ready", 64'(ready), 64'(0));
    check("midclr_rvalid", 64'(rvalid), 64'(0));
    check("midclr_data_out", 64'(data_out), 64'(0));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    wait_ready("reclear_cycles", 32);
    drive(0, 1, 0, 5'd3, '0, '0);
    drive(1, 1, 0, 5'd31, 32'hA5A5_5A5A, 4'b1010);
    drive(0, 1, 0, 5'd31, '0, '0);
    drive(0, 0, 0, '0, '0, '0);

    // 64-bit x 8-word instance.
    rst64 = 1'b0;
    cnt = 0;
    while (!rdy64 && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("w64_clear_cycles", 64'(cnt), 64'(8));
    we64 = 1; a64 = 3'd2; d64 = 64'h1122334455667788; be64 = 8'hFF;
    @(posedge clk); #1;
    d64 = 64'hAAAAAAAAAAAAAAAA; be64 = 8'h0F;
    @(posedge clk); #1;
    we64 = 0; re64 = 1;
    @(posedge clk); #1;
    check("w64_rvalid", 64'(rv64), 64'(1));
    check("w64_low_lanes", dout64, 64'h11223344AAAAAAAA);
    a64 = 3'd6;
    @(posedge clk); #1;
    check("w64_cleared", dout64, 64'h0);
    re64 = 0;
    @(posedge clk); #1;
    check("w64_rvalid_drop", 64'(rv64), 64'(0));
    check("w64_hold", dout64, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
